exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage ARM-subset pipeline, directly downstream of the ID/EXE register that carries the control unit's `exe_cmd`, memory enables, write-back enable, branch bit and status-write bit. It computes the ALU result and NZCV flags, owns the architectural status register, and resolves the branch target. It also holds the EXE/MEM pipeline register feeding the memory stage.

## Interface
- No parameters. Data width is fixed at 32 and register index width at 4.
- `clk` in 1: pipeline clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `freeze` in 1: hold the EXE/MEM register and the status register.
- `flush` in 1: insert a bubble into the EXE/MEM register.
- `exe_cmd` in 4: ALU operation. The encoding is:
  - MOV=0001, MVN=1001
  - ADD/LDR/STR=0010, ADC=0011
  - SUB/CMP=0100, SBC=0101
  - AND/TST=0110, ORR=0111, EOR=1000
- `mem_r_en`, `mem_w_en`, `wb_en` in 1 each: control bits passed to the memory stage.
- `b` in 1: branch instruction, already condition-qualified.
- `s` in 1: status write enable.
- `pc` in 32: PC+4 of the instruction in EXE.
- `val_rn` in 32: first operand.
- `val2` in 32: second operand, already shifted or immediate.
- `val_rm` in 32: store data.
- `imm24` in 24: branch offset field.
- `dest` in 4: destination register index.
- `status` out 4: registered NZCV, with bit 3 = N and bit 0 = V.
- `br_taken` out 1: combinational, equals `b`.
- `br_addr` out 32: combinational, `pc + (sign_extend(imm24) << 2)`, modulo 2^32.
- `alu_res_out` out 32: registered.
- `val_rm_out` out 32: registered.
- `dest_out` out 4: registered.
- `wb_en_out`, `mem_r_en_out`, `mem_w_en_out` out 1 each: registered.

## Operation
- The ALU is combinational on `exe_cmd`, `val_rn`, `val2` and the current registered C flag. A is `val_rn`, B is `val2`, Cin is `status[1]`.
  - MOV: B. MVN: ~B.
  - ADD: A+B. ADC: A+B+Cin.
  - SUB: A−B. SBC: A−B−(~Cin).
  - AND: A&B. ORR: A|B. EOR: A^B.
  - Any unlisted encoding gives a result of 0.
- N and Z follow every op: N = res[31], Z = (res == 0).
- C and V for arithmetic ops:
  - ADD/ADC: C = carry-out of the 33-bit sum. V = operands have the same sign and the result sign differs.
  - SUB/SBC: C = NOT borrow (1 when A ≥ B+borrow, unsigned). V = operands have different signs and the result sign differs from A.
- Logical ops and MOV/MVN keep the current C and V.
- Status register write condition: `s`=1 AND `mem_r_en`=0 AND `mem_w_en`=0 AND `freeze`=0. Memory ops never change flags, even when `s`=1.
- CMP and TST arrive with `wb_en`=0 and `s`=1. They update flags only.
- LDR/STR use the ADD path, so `alu_res_out` = `val_rn + val2` (effective address).
- EXE/MEM register update, priority order:
  - `rst`: clear all registered outputs and `status` to 0.
  - `flush`: clear `wb_en_out`, `mem_r_en_out` and `mem_w_en_out`; data fields are don't-care but are written as 0. Status follows its own write condition.
  - `freeze`: hold all registered outputs and `status`.
  - Otherwise: capture the ALU result, `val_rm`, `dest` and the control bits.
- `flush` takes priority over `freeze` when both are high.
- Branch outputs are purely combinational. The hazard/IF logic consumes them in the same cycle.

## Timing
- Latency is 1 cycle: operands valid in cycle n appear on the registered outputs after edge n+1.
- A status update from instruction n is visible at edge n+1. An ADC/SBC in cycle n+1 uses that updated carry, so back-to-back flag dependence needs no stall.
- Reset values: `status`=0000, all registered outputs 0.
- Reset in the middle of a stream discards the in-flight result. The first post-reset edge with `rst`=0 captures normally.
- `br_addr` wraps modulo 2^32. A negative offset is produced by sign extension of imm24[23].

## Test plan
- Reset, then ADD with `s`=1, 0x7FFFFFFF + 0x00000001 → next edge: `alu_res_out`=0x80000000, `status`=1001 (N=1, V=1).
- SUB with `s`=1, 5 − 5 → `alu_res_out`=0, `status`=0110. Then SBC with `s`=0, 10 − 3 → `alu_res_out`=7 (C=1, so no extra borrow) and `status` is unchanged.
- CMP 3,5 with `wb_en`=0 → `status`=1000 (N=1, C=0) and `wb_en_out`=0. Then ADC 1+1 → 2.
- LDR with `s`=1, `val_rn`=0x400, `val2`=8 → `alu_res_out`=0x408, `mem_r_en_out`=1, `status` unchanged.
- `b`=1, `pc`=0x100, imm24=0xFFFFFE → `br_taken`=1 and `br_addr`=0xF8 in the same cycle.
- ADD with `freeze`=1 → outputs and status hold. Assert `flush` and `freeze` together → control outputs become 0 next edge.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: ALU with NZCV generation, architectural status register,
// branch target resolution and the EXE/MEM pipeline register.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic [3:0]  exe_cmd,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        wb_en,
    input  logic        b,
    input  logic        s,
    input  logic [31:0] pc,
    input  logic [31:0] val_rn,
    input  logic [31:0] val2,
    input  logic [31:0] val_rm,
    input  logic [23:0] imm24,
    input  logic [3:0]  dest,
    output logic [3:0]  status,
    output logic        br_taken,
    output logic [31:0] br_addr,
    output logic [31:0] alu_res_out,
    output logic [31:0] val_rm_out,
    output logic [3:0]  dest_out,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    // Returns {result[31:0], N, Z, C, V}. Subtraction is done as A + ~B + carry
    // so the adder carry-out is directly the ARM "not borrow" C flag.
    function automatic logic [35:0] alu_calc(
        input logic [3:0]  cmd,
        input logic [31:0] a,
        input logic [31:0] bv,
        input logic [3:0]  flags
    );
        logic [32:0] sum;
        logic [31:0] res;
        logic        c;
        logic        v;
        sum = '0;
        res = '0;
        c   = flags[1];
        v   = flags[0];
        case (cmd)
            CMD_MOV: res = bv;
            CMD_MVN: res = ~bv;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, a} + {1'b0, bv} +
                      {32'd0, (cmd == CMD_ADC) ? flags[1] : 1'b0};
                res = sum[31:0];
                c   = sum[32];
                v   = (a[31] == bv[31]) && (res[31] != a[31]);
            end
            CMD_SUB, CMD_SBC: begin
                sum = {1'b0, a} + {1'b0, ~bv} +
                      {32'd0, (cmd == CMD_SBC) ? flags[1] : 1'b1};
                res = sum[31:0];
                c   = sum[32];
                v   = (a[31] != bv[31]) && (res[31] != a[31]);
            end
            CMD_AND: res = a & bv;
            CMD_ORR: res = a | bv;
            CMD_EOR: res = a ^ bv;
            default: res = '0;
        endcase
        return {res, res[31], (res == 32'd0), c, v};
    endfunction

    logic [35:0]        alu_p0;
    logic [31:0]        alu_res_p0;
    logic [3:0]         nzcv_p0;
    logic               status_we_p0;
    logic signed [31:0] br_off_p0;

    logic [3:0]  status_p1;
    logic [31:0] alu_res_p1;
    logic [31:0] val_rm_p1;
    logic [3:0]  dest_p1;
    logic        wb_en_p1;
    logic        mem_r_en_p1;
    logic        mem_w_en_p1;

    // Stage p0: combinational ALU, flag write qualification and branch target
    always_comb begin
        alu_p0       = alu_calc(exe_cmd, val_rn, val2, status_p1);
        alu_res_p0   = alu_p0[35:4];
        nzcv_p0      = alu_p0[3:0];
        status_we_p0 = s && !mem_r_en && !mem_w_en && !freeze;
        br_off_p0    = {{6{imm24[23]}}, imm24, 2'b00};
    end

    assign br_taken = b;
    assign br_addr  = pc + $unsigned(br_off_p0);

    // Status register: independent of flush, held by freeze, never written by memory ops
    always_ff @(posedge clk) begin
        if (rst) begin
            status_p1 <= '0;
        end else if (status_we_p0) begin
            status_p1 <= nzcv_p0;
        end
    end

    // Stage p1: EXE/MEM register; flush outranks freeze so a bubble always lands
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_res_p1  <= '0;
            val_rm_p1   <= '0;
            dest_p1     <= '0;
            wb_en_p1    <= 1'b0;
            mem_r_en_p1 <= 1'b0;
            mem_w_en_p1 <= 1'b0;
        end else if (!freeze) begin
            alu_res_p1  <= alu_res_p0;
            val_rm_p1   <= val_rm;
            dest_p1     <= dest;
            wb_en_p1    <= wb_en;
            mem_r_en_p1 <= mem_r_en;
            mem_w_en_p1 <= mem_w_en;
        end
    end

    assign status       = status_p1;
    assign alu_res_out  = alu_res_p1;
    assign val_rm_out   = val_rm_p1;
    assign dest_out     = dest_p1;
    assign wb_en_out    = wb_en_p1;
    assign mem_r_en_out = mem_r_en_p1;
    assign mem_w_en_out = mem_w_en_p1;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table through a scoreboard queue,
// plus hand-written branch, freeze/flush and mid-stream reset sequences.
module tb_exe_stage;

    localparam logic [3:0] MOV = 4'b0001;
    localparam logic [3:0] MVN = 4'b1001;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] ADC = 4'b0011;
    localparam logic [3:0] SUB = 4'b0100;
    localparam logic [3:0] SBC = 4'b0101;
    localparam logic [3:0] AND = 4'b0110;
    localparam logic [3:0] ORR = 4'b0111;
    localparam logic [3:0] EOR = 4'b1000;
    localparam logic [3:0] BAD = 4'b0000;

    logic        clk = 1'b0;
    logic        rst, freeze, flush;
    logic [3:0]  exe_cmd;
    logic        mem_r_en, mem_w_en, wb_en, b, s;
    logic [31:0] pc, val_rn, val2, val_rm;
    logic [23:0] imm24;
    logic [3:0]  dest;
    logic [3:0]  status;
    logic        br_taken;
    logic [31:0] br_addr, alu_res_out, val_rm_out;
    logic [3:0]  dest_out;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en(wb_en), .b(b), .s(s), .pc(pc), .val_rn(val_rn),
        .val2(val2), .val_rm(val_rm), .imm24(imm24), .dest(dest),
        .status(status), .br_taken(br_taken), .br_addr(br_addr),
        .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
        .dest_out(dest_out), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic        mr, mw, wb, sb;
        logic [31:0] rn, v2, rm;
        logic [3:0]  dst;
        logic [31:0] exp_res;
        logic [3:0]  exp_st;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rm;
        logic [3:0]  st;
        logic [3:0]  dst;
        logic [2:0]  ctl;   // {wb, mr, mw}
    } exp_t;

    vec_t vecs [19];
    exp_t sbq [$];
    exp_t last;
    int   checks = 0;
    int   failures = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] cmd, input logic mr, input logic mw,
                         input logic wb, input logic sb, input logic [31:0] rn,
                         input logic [31:0] v2, input logic [31:0] rm,
                         input logic [3:0] dst);
        exe_cmd = cmd; mem_r_en = mr; mem_w_en = mw; wb_en = wb; s = sb;
        val_rn = rn; val2 = v2; val_rm = rm; dest = dst;
    endtask

    task automatic push(input logic [31:0] res, input logic [31:0] rm,
                        input logic [3:0] st, input logic [3:0] dst,
                        input logic [2:0] ctl);
        exp_t e;
        e.res = res; e.rm = rm; e.st = st; e.dst = dst; e.ctl = ctl;
        sbq.push_back(e);
    endtask

    // Advance one edge and compare the registered outputs to the scoreboard head
    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got res %h", tag, alu_res_out);
        end else begin
            e = sbq.pop_front();
            cmp({tag, ".res"},  alu_res_out, e.res);
            cmp({tag, ".st"},   {28'd0, status}, {28'd0, e.st});
            cmp({tag, ".rm"},   val_rm_out, e.rm);
            cmp({tag, ".dst"},  {28'd0, dest_out}, {28'd0, e.dst});
            cmp({tag, ".ctl"},  {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out},
                                {29'd0, e.ctl});
            last = e;
        end
    endtask

    initial begin
        vecs[0]  = '{ADD, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 32'h1, 32'h11, 4'h1, 32'h80000000, 4'b1001};
        vecs[1]  = '{SUB, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5, 32'h5, 32'h22, 4'h2, 32'h0, 4'b0110};
        vecs[2]  = '{SBC, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA, 32'h3, 32'h33, 4'h3, 32'h7, 4'b0110};
        vecs[3]  = '{SUB, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3, 32'h5, 32'h44, 4'h4, 32'hFFFFFFFE, 4'b1000};
        vecs[4]  = '{ADC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h1, 32'h55, 4'h5, 32'h2, 4'b1000};
        vecs[5]  = '{ADD, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h8, 32'h66, 4'h6, 32'h408, 4'b1000};
        vecs[6]  = '{ADD, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h4, 32'hDEAD, 4'h7, 32'h104, 4'b1000};
        vecs[7]  = '{MVN, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 4'h8, 32'hFFFFFFFF, 4'b1000};
        vecs[8]  = '{ADD, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0, 4'h9, 32'h0, 4'b0110};
        vecs[9]  = '{ADC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1, 32'h2, 32'h0, 4'hA, 32'h4, 4'b0000};
        vecs[10] = '{SUB, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80000000, 32'h1, 32'h0, 4'hB, 32'h7FFFFFFF, 4'b0011};
        vecs[11] = '{AND, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF0, 32'h3C, 32'h0, 4'hC, 32'h30, 4'b0011};
        vecs[12] = '{ORR, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF0, 32'h0F, 32'h0, 4'hD, 32'hFF, 4'b0011};
        vecs[13] = '{EOR, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFF, 32'hFF, 32'h0, 4'hE, 32'h0, 4'b0111};
        vecs[14] = '{SBC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5, 32'h5, 32'h0, 4'hF, 32'h0, 4'b0110};
        vecs[15] = '{MOV, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h80000000, 32'h0, 4'h1, 32'h80000000, 4'b1010};
        vecs[16] = '{SUB, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3, 32'h5, 32'h0, 4'h2, 32'hFFFFFFFE, 4'b1000};
        vecs[17] = '{SBC, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA, 32'h3, 32'h0, 4'h3, 32'h6, 4'b1000};
        vecs[18] = '{BAD, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5, 32'h6, 32'h0, 4'h4, 32'h0, 4'b0100};

        rst = 1'b1; freeze = 1'b0; flush = 1'b0; b = 1'b0;
        pc = 32'h0; imm24 = 24'h0;
        drive(ADD, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234, 32'h5678, 32'h9ABC, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.res", alu_res_out, 32'h0);
        cmp("reset.st",  {28'd0, status}, 32'h0);
        cmp("reset.rm",  val_rm_out, 32'h0);
        cmp("reset.dst", {28'd0, dest_out}, 32'h0);
        cmp("reset.ctl", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'h0);
        rst = 1'b0;

        // Table of single-cycle operations with chained flag dependence
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].cmd, vecs[i].mr, vecs[i].mw, vecs[i].wb, vecs[i].sb,
                  vecs[i].rn, vecs[i].v2, vecs[i].rm, vecs[i].dst);
            push(vecs[i].exp_res, vecs[i].rm, vecs[i].exp_st, vecs[i].dst,
                 {vecs[i].wb, vecs[i].mr, vecs[i].mw});
            tick_check($sformatf("vec%0d", i));
        end

        // Branch target: combinational, same cycle
        b = 1'b1; pc = 32'h100; imm24 = 24'hFFFFFE;
        #1;
        cmp("br.taken", {31'd0, br_taken}, 32'h1);
        cmp("br.neg",   br_addr, 32'h000000F8);
        pc = 32'hFFFFFFF0; imm24 = 24'h000010;
        #1;
        cmp("br.wrap",  br_addr, 32'h00000030);
        b = 1'b0; pc = 32'h2000; imm24 = 24'h800000;
        #1;
        cmp("br.nottaken", {31'd0, br_taken}, 32'h0);
        cmp("br.minoff", br_addr, 32'hFE002000);

        // Freeze holds everything including status
        freeze = 1'b1;
        drive(ADD, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7, 32'h8, 32'h99, 4'h9);
        push(last.res, last.rm, last.st, last.dst, last.ctl);
        tick_check("freeze");

        // Flush with freeze: bubble lands, status still held
        flush = 1'b1;
        drive(ADD, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h77, 4'h7);
        push(32'h0, 32'h0, 4'b0100, 4'h0, 3'b000);
        tick_check("flushfrz");

        // Flush alone: bubble, but status takes the flag write
        freeze = 1'b0;
        drive(SUB, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3, 32'h5, 32'h77, 4'h7);
        push(32'h0, 32'h0, 4'b1000, 4'h0, 3'b000);
        tick_check("flush");
        flush = 1'b0;

        // Mid-stream reset discards the in-flight op, next edge captures normally
        rst = 1'b1;
        drive(ADD, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7FFFFFFF, 32'h1, 32'h55, 4'h5);
        push(32'h0, 32'h0, 4'b0000, 4'h0, 3'b000);
        tick_check("midrst");
        rst = 1'b0;
        drive(ADD, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2, 32'h3, 32'h66, 4'h6);
        push(32'h5, 32'h66, 4'b0000, 4'h6, 3'b100);
        tick_check("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
